ttm_alu_serial: RTL and testbench
=================================

// Module: ttm_alu_serial
// PURPOSE
//  Parametrised, slice-serial successor to the TTM4 4-bit ALU.
//  - Processes a WIDTH-bit word one SLICE-bit slice per clock, LSB slice first, chaining carry between slices.
//  - Same 4-bit slice datapath serves 8/12/16-bit TTM words.
//  - Start/busy/done handshake; Z/C flags registered at operation completion.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of SLICE, >= SLICE
//  SLICE   4  bits processed per clock; N = WIDTH/SLICE cycles per operation
// PORTS
//  CLK        in   1      clock, rising edge
//  RST        in   1      asynchronous active-low reset
//  START      in   1      request; sampled only when BUSY=0
//  OP         in   3      0 ADD, 1 ADC, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 PASS Y, 7 PASS X
//  X          in   WIDTH  operand A, captured with START
//  Y          in   WIDTH  operand B, captured with START
//  BUSY       out  1      operation in progress
//  DONE       out  1      one-cycle pulse; RESULT/flags valid from this cycle
//  RESULT     out  WIDTH  last completed result; held until next DONE
//  Z_FLAG     out  1      RESULT == 0
//  C_FLAG     out  1      carry out of MSB (SUB: 1 = no borrow)
//  V_FLAG     out  1      signed overflow; only present with TTM_ALU_OVF_EN
// BEHAVIOUR
//  Reset (RST=0, async, any state): state IDLE; BUSY=0; DONE=0; RESULT=0; Z_FLAG=0; C_FLAG=0; V_FLAG=0.
//  - Aborts any operation in flight; partial results are discarded.
//  FSM: IDLE -> RUN -> DONE_ST -> IDLE.
//  - IDLE: START=1 at edge t captures X, Y, OP; clears slice index k and the zero accumulator; goes to RUN.
//    BUSY=1 from edge t.
//  - RUN: edge t+1+k processes slice k, k = 0..N-1.
//    - Slice carry-in: k=0 uses 0 for ADD, C_FLAG for ADC, 1 for SUB.
//    - SUB computes X + ~Y + 1.
//    - Slice result shifts into an internal shift register; the zero accumulator is ANDed with (slice==0).
//    - After slice N-1 (edge t+N), go to DONE_ST.
//  - DONE_ST: lasts exactly one cycle. DONE=1, BUSY=0.
//    - RESULT and flags are loaded on edge t+N, so they are visible in the same cycle as DONE.
//    - A START sampled in this cycle is accepted exactly as in IDLE (back-to-back).
//    - With no START, the next state is IDLE.
//  Latency: DONE is asserted N cycles after the START edge; throughput is one op per N+1 cycles.
//  Arithmetic: all modulo 2^WIDTH; the slice carry chain is internal and SLICE+1 bits wide.
//  Flag update rules (at DONE only):
//  - Z_FLAG: updated for every OP.
//  - C_FLAG: updated for OP 0-2 only; logic/pass ops hold the previous C_FLAG.
//  - Flags and RESULT never change during RUN.
//  Boundary cases:
//  - START while BUSY=1: ignored; no queueing.
//  - X/Y/OP changes during RUN: no effect, because operands were captured at START.
//  - ADC uses the C_FLAG value held at START capture.
//  - N=1 (WIDTH==SLICE): RUN lasts one cycle; DONE one cycle after START.
// CONFIGURATION
//  TTM_ALU_OVF_EN defined:
//  - V_FLAG port exists.
//  - Reset 0. Updated at DONE for OP 0-2 as carry-into-MSB XOR carry-out-of-MSB.
//  - Held for other ops.
//  TTM_ALU_OVF_EN undefined:
//  - V_FLAG port and its logic are absent.
//  - All other behaviour is identical.
// TESTING (WIDTH=16, SLICE=4, N=4)
//  1. Reset: RST=0 mid-RUN -> BUSY=0, DONE=0, RESULT=0, Z=0, C=0 immediately. After release, no DONE appears without a new START.
//  2. ADD X=FFFF Y=0001 -> DONE exactly 4 cycles after START; RESULT=0000, Z=1, C=1; BUSY high for 4 cycles.
//  3. Then ADC X=1234 Y=0001 (C=1) -> RESULT=1236, Z=0, C=0.
//     Then SUB 0003-0005 -> RESULT=FFFE, C=0.
//     Then SUB 0005-0005 -> RESULT=0000, Z=1, C=1.
//  4. After an op leaving C=1: AND F0F0 & 0FF0 -> RESULT=00F0, Z=0, C stays 1.
//     Then XOR AAAA ^ AAAA -> RESULT=0000, Z=1. PASS Y 5A5A -> RESULT=5A5A.
//  5. Handshake: START pulses while BUSY=1 are ignored, and X/Y change during RUN, yet RESULT matches the captured operands.
//     START in the DONE cycle -> the next DONE follows 4 cycles later; no idle gap is needed.
//  6. With TTM_ALU_OVF_EN: ADD 7FFF+0001 -> RESULT=8000, V=1, C=0; SUB 8000-0001 -> RESULT=7FFF, V=1.
//     Without the macro: the design elaborates with no V_FLAG port.

Source files
------------

// File: rtl/ttm_alu_serial.sv
// Slice-serial TTM ALU: WIDTH-bit operation processed SLICE bits per clock, LSB slice first.
// Optional signed-overflow flag V_FLAG is built only when TTM_ALU_OVF_EN is defined.
module ttm_alu_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             Z_FLAG,
    output logic             C_FLAG
`ifdef TTM_ALU_OVF_EN
    ,
    output logic             V_FLAG
`endif
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_e;
    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_ADC   = 3'd1,
        OP_SUB   = 3'd2,
        OP_AND   = 3'd3,
        OP_OR    = 3'd4,
        OP_XOR   = 3'd5,
        OP_PASSY = 3'd6,
        OP_PASSX = 3'd7
    } op_e;

    state_e           state;
    op_e              op_r;
    logic [WIDTH-1:0] x_sr;
    logic [WIDTH-1:0] y_sr;
    logic [WIDTH-1:0] res_sr;
    logic [KW-1:0]    k;
    logic             carry;
    logic             zero_acc;

    logic [SLICE-1:0]       a;
    logic [SLICE-1:0]       b_raw;
    logic [SLICE-1:0]       b;
    logic [SLICE:0]         sum;
    logic [SLICE-1:0]       slice_res;
    logic [WIDTH+SLICE-1:0] cat;
    logic [WIDTH-1:0]       res_next;
    logic                   is_arith;
    logic                   last;
    logic                   slice_zero;

    always_comb begin
        a          = x_sr[SLICE-1:0];
        b_raw      = y_sr[SLICE-1:0];
        b          = (op_r == OP_SUB) ? ~b_raw : b_raw;
        sum        = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, carry};
        slice_res  = '0;
        case (op_r)
            OP_ADD, OP_ADC, OP_SUB: slice_res = sum[SLICE-1:0];
            OP_AND:                 slice_res = a & b_raw;
            OP_OR:                  slice_res = a | b_raw;
            OP_XOR:                 slice_res = a ^ b_raw;
            OP_PASSY:               slice_res = b_raw;
            OP_PASSX:               slice_res = a;
            default:                slice_res = '0;
        endcase
        // New slice enters at the top so the LSB slice ends at bit 0 after N shifts.
        cat        = {slice_res, res_sr};
        res_next   = WIDTH'(cat >> SLICE);
        is_arith   = (op_r == OP_ADD) || (op_r == OP_ADC) || (op_r == OP_SUB);
        last       = (k == KW'(N - 1));
        slice_zero = (slice_res == '0);
    end

`ifdef TTM_ALU_OVF_EN
    logic v_next;
    // Carry into the word MSB is recovered from the sum bit of the top slice position.
    assign v_next = sum[SLICE] ^ (a[SLICE-1] ^ b[SLICE-1] ^ sum[SLICE-1]);
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            op_r     <= OP_ADD;
            x_sr     <= '0;
            y_sr     <= '0;
            res_sr   <= '0;
            k        <= '0;
            carry    <= 1'b0;
            zero_acc <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            RESULT   <= '0;
            Z_FLAG   <= 1'b0;
            C_FLAG   <= 1'b0;
`ifdef TTM_ALU_OVF_EN
            V_FLAG   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE_ST: begin
                    DONE <= 1'b0;
                    if (START) begin
                        x_sr     <= X;
                        y_sr     <= Y;
                        op_r     <= op_e'(OP);
                        carry    <= (op_e'(OP) == OP_ADC) ? C_FLAG : (op_e'(OP) == OP_SUB);
                        zero_acc <= 1'b1;
                        k        <= '0;
                        BUSY     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    x_sr     <= x_sr >> SLICE;
                    y_sr     <= y_sr >> SLICE;
                    res_sr   <= res_next;
                    carry    <= sum[SLICE];
                    zero_acc <= zero_acc & slice_zero;
                    k        <= k + 1'b1;
                    if (last) begin
                        state  <= DONE_ST;
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        RESULT <= res_next;
                        Z_FLAG <= zero_acc & slice_zero;
                        if (is_arith) begin
                            C_FLAG <= sum[SLICE];
`ifdef TTM_ALU_OVF_EN
                            V_FLAG <= v_next;
`endif
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttm_alu_serial.sv
// Scoreboard bench for ttm_alu_serial (WIDTH=16, SLICE=4): full-width reference model,
// expected results queued at START and compared when DONE appears.
module tb_ttm_alu_serial;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [2:0]  OP;
  logic [15:0] X;
  logic [15:0] Y;
  logic        BUSY;
  logic        DONE;
  logic [15:0] RESULT;
  logic        Z_FLAG;
  logic        C_FLAG;
`ifdef TTM_ALU_OVF_EN
  logic        V_FLAG;
`endif

  ttm_alu_serial #(.WIDTH(16), .SLICE(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .OP     (OP),
    .X      (X),
    .Y      (Y),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT),
    .Z_FLAG (Z_FLAG),
`ifdef TTM_ALU_OVF_EN
    .V_FLAG (V_FLAG),
`endif
    .C_FLAG (C_FLAG)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic model_c = 1'b0;
  logic model_v = 1'b0;

  task automatic push_expected(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    logic [16:0] s;
    logic [15:0] yy;
    exp_t        e;
    yy = (op == 3'd2) ? ~y : y;
    case (op)
      3'd0:    s = {1'b0, x} + {1'b0, y};
      3'd1:    s = {1'b0, x} + {1'b0, y} + {16'd0, model_c};
      3'd2:    s = {1'b0, x} + {1'b0, yy} + 17'd1;
      3'd3:    s = {1'b0, x & y};
      3'd4:    s = {1'b0, x | y};
      3'd5:    s = {1'b0, x ^ y};
      3'd6:    s = {1'b0, y};
      default: s = {1'b0, x};
    endcase
    e.res = s[15:0];
    e.z   = (s[15:0] == 16'h0000);
    e.c   = model_c;
    e.v   = model_v;
    if (op <= 3'd2) begin
      e.c = s[16];
      e.v = (x[15] == yy[15]) && (s[15] != x[15]);
    end
    model_c = e.c;
    model_v = e.v;
    sb.push_back(e);
  endtask

  // Drives one operation and waits (bounded) for DONE; returns what the DUT showed.
  task automatic run_op(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                        input bit b2b, input bit noise,
                        output int lat, output int busy_cnt,
                        output logic [15:0] res, output logic z, output logic c, output logic v);
    if (!b2b) @(negedge CLK);
    OP = op; X = x; Y = y; START = 1'b1;
    push_expected(op, x, y);
    lat = 99; busy_cnt = 0; res = 'x; z = 1'bx; c = 1'bx; v = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (DONE) begin
        lat = i - 1;
        res = RESULT; z = Z_FLAG; c = C_FLAG;
`ifdef TTM_ALU_OVF_EN
        v = V_FLAG;
`else
        v = 1'b0;
`endif
        break;
      end
      if (BUSY) busy_cnt++;
      START = noise;
      if (noise) begin
        X  = 16'($urandom);
        Y  = 16'($urandom);
        OP = 3'($urandom);
      end
    end
    START = 1'b0;
  endtask

  task automatic test_reset();
    int lat, bc; logic [15:0] r; logic z, c, v; exp_t e;
    RST = 1'b0; START = 1'b0; OP = '0; X = '0; Y = '0;
    #1;
    checks++;
    if ({BUSY, DONE, RESULT, Z_FLAG, C_FLAG} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h z=%b c=%b, want all 0",
               BUSY, DONE, RESULT, Z_FLAG, C_FLAG);
    end
    @(negedge CLK); RST = 1'b1;
    run_op(3'd0, 16'hFFFF, 16'hFFFF, 0, 0, lat, bc, r, z, c, v);
    e = sb.pop_front();
    checks++;
    if ({lat, r, z, c} !== {32'sd4, e.res, e.z, e.c}) begin
      errors++;
      $display("FAIL reset_preop: got lat=%0d res=%h z=%b c=%b, want lat=4 res=%h z=%b c=%b",
               lat, r, z, c, e.res, e.z, e.c);
    end
    @(negedge CLK);
    START = 1'b1; OP = 3'd0; X = 16'h0001; Y = 16'h0001;
    @(negedge CLK); START = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if ({BUSY, DONE, RESULT, Z_FLAG, C_FLAG} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_midrun: got busy=%b done=%b res=%h z=%b c=%b, want all 0",
               BUSY, DONE, RESULT, Z_FLAG, C_FLAG);
    end
    model_c = 1'b0; model_v = 1'b0;
    @(negedge CLK); RST = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge CLK);
        if (DONE || BUSY) seen++;
      end
      checks++;
      if (seen !== 0) begin
        errors++;
        $display("FAIL reset_no_done: got %0d busy/done cycles after release, want 0", seen);
      end
    end
  endtask

  task automatic test_arith();
    logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd2, 3'd2};
    logic [15:0] xs  [4] = '{16'hFFFF, 16'h1234, 16'h0003, 16'h0005};
    logic [15:0] ys  [4] = '{16'h0001, 16'h0001, 16'h0005, 16'h0005};
    logic [15:0] er  [4] = '{16'h0000, 16'h1236, 16'hFFFE, 16'h0000};
    logic        ez  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        ec  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int lat, bc; logic [15:0] r; logic z, c, v; exp_t e;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], xs[i], ys[i], 0, 0, lat, bc, r, z, c, v);
      e = sb.pop_front();
      checks++;
      if (lat !== 4 || bc !== 4) begin
        errors++;
        $display("FAIL arith_timing[%0d]: got lat=%0d busy=%0d, want lat=4 busy=4", i, lat, bc);
      end
      checks++;
      if ({r, z, c} !== {e.res, e.z, e.c}) begin
        errors++;
        $display("FAIL arith_model[%0d]: got res=%h z=%b c=%b, want res=%h z=%b c=%b",
                 i, r, z, c, e.res, e.z, e.c);
      end
      checks++;
      if ({r, z, c} !== {er[i], ez[i], ec[i]}) begin
        errors++;
        $display("FAIL arith_const[%0d]: got res=%h z=%b c=%b, want res=%h z=%b c=%b",
                 i, r, z, c, er[i], ez[i], ec[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [2:0]  ops [5] = '{3'd3, 3'd5, 3'd6, 3'd4, 3'd7};
    logic [15:0] xs  [5] = '{16'hF0F0, 16'hAAAA, 16'h1111, 16'h0F00, 16'hC3C3};
    logic [15:0] ys  [5] = '{16'h0FF0, 16'hAAAA, 16'h5A5A, 16'h00F0, 16'h0000};
    int lat, bc; logic [15:0] r; logic z, c, v; exp_t e;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], xs[i], ys[i], 0, 0, lat, bc, r, z, c, v);
      e = sb.pop_front();
      checks++;
      if (lat !== 4 || {r, z, c} !== {e.res, e.z, e.c}) begin
        errors++;
        $display("FAIL logic[%0d]: got lat=%0d res=%h z=%b c=%b, want lat=4 res=%h z=%b c=%b",
                 i, lat, r, z, c, e.res, e.z, e.c);
      end
    end
  endtask

  task automatic test_handshake();
    int lat, bc; logic [15:0] r; logic z, c, v; exp_t e; int seen;
    run_op(3'd0, 16'h1111, 16'h2222, 0, 1, lat, bc, r, z, c, v);
    e = sb.pop_front();
    checks++;
    if (lat !== 4 || {r, z, c} !== {16'h3333, e.z, e.c} || r !== e.res) begin
      errors++;
      $display("FAIL handshake: got lat=%0d res=%h z=%b c=%b, want lat=4 res=%h z=%b c=%b",
               lat, r, z, c, e.res, e.z, e.c);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (DONE || BUSY) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL handshake_no_queue: got %0d busy/done cycles, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd2, 3'd5};
    logic [15:0] xs  [4] = '{16'h8000, 16'h0100, 16'h0010, 16'h1234};
    logic [15:0] ys  [4] = '{16'h8000, 16'h0200, 16'h0020, 16'h4321};
    int lat, bc; logic [15:0] r; logic z, c, v; exp_t e;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], xs[i], ys[i], i != 0, 0, lat, bc, r, z, c, v);
      e = sb.pop_front();
      checks++;
      if (lat !== 4 || {r, z, c} !== {e.res, e.z, e.c}) begin
        errors++;
        $display("FAIL b2b[%0d]: got lat=%0d res=%h z=%b c=%b, want lat=4 res=%h z=%b c=%b",
                 i, lat, r, z, c, e.res, e.z, e.c);
      end
    end
  endtask

  task automatic test_random();
    int lat, bc; logic [15:0] r; logic z, c, v; exp_t e;
    for (int i = 0; i < 12; i++) begin
      run_op(3'($urandom), 16'($urandom), 16'($urandom), (i != 0) && ($urandom_range(0, 1) == 1), 0,
             lat, bc, r, z, c, v);
      e = sb.pop_front();
      checks++;
      if (lat !== 4 || {r, z, c} !== {e.res, e.z, e.c}) begin
        errors++;
        $display("FAIL random[%0d]: got lat=%0d res=%h z=%b c=%b, want lat=4 res=%h z=%b c=%b",
                 i, lat, r, z, c, e.res, e.z, e.c);
      end
`ifdef TTM_ALU_OVF_EN
      checks++;
      if (v !== e.v) begin
        errors++;
        $display("FAIL random_v[%0d]: got v=%b, want v=%b", i, v, e.v);
      end
`endif
    end
  endtask

`ifdef TTM_ALU_OVF_EN
  task automatic test_ovf();
    int lat, bc; logic [15:0] r; logic z, c, v; exp_t e;
    run_op(3'd0, 16'h7FFF, 16'h0001, 0, 0, lat, bc, r, z, c, v);
    e = sb.pop_front();
    checks++;
    if ({r, v, c} !== {16'h8000, 1'b1, 1'b0} || {r, v, c} !== {e.res, e.v, e.c}) begin
      errors++;
      $display("FAIL ovf_add: got res=%h v=%b c=%b, want res=8000 v=1 c=0", r, v, c);
    end
    run_op(3'd2, 16'h8000, 16'h0001, 0, 0, lat, bc, r, z, c, v);
    e = sb.pop_front();
    checks++;
    if ({r, v} !== {16'h7FFF, 1'b1} || {r, v} !== {e.res, e.v}) begin
      errors++;
      $display("FAIL ovf_sub: got res=%h v=%b, want res=7fff v=1", r, v);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_handshake();
    test_back_to_back();
    test_random();
`ifdef TTM_ALU_OVF_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
